// File: rtl/contador_bcd_4_digitos_pkg.sv
// Shared types and constants for the BCD counter and the 7-segment display path.
// Digit type, BCD limits, run/stop state encoding and a single-digit step helper.
package pkg_display;

  typedef logic [3:0] bcd_t;

  localparam bcd_t C_BCD_MAX     = 4'd9;
  localparam bcd_t C_BCD_MIN     = 4'd0;
  localparam int   C_NUM_DIGITOS = 4;

  typedef enum logic {
    DETENIDO  = 1'b0,
    CORRIENDO = 1'b1
  } estado_t;

  // Out-of-range codes fold back into 0..9 so a digit can never stay illegal.
  function automatic bcd_t bcd_paso(input bcd_t digito, input logic sube);
    bcd_t resultado;
    if (sube) begin
      if (digito >= C_BCD_MAX) resultado = C_BCD_MIN;
      else                     resultado = digito + 4'd1;
    end else begin
      if (digito == C_BCD_MIN)     resultado = C_BCD_MAX;
      else if (digito > C_BCD_MAX) resultado = C_BCD_MAX;
      else                         resultado = digito - 4'd1;
    end
    return resultado;
  endfunction

endpackage

// File: rtl/contador_bcd_4_digitos_digito_bcd.sv
// One BCD digit register with enable, direction and synchronous clear.
// acarreo_o flags that the next enabled step will wrap this digit (carry up / borrow down).
module digito_bcd
  import pkg_display::*;
(
  input  logic       reloj_i,
  input  logic       reset_i,
  input  logic       habilita_i,
  input  logic       sube_i,
  input  logic       limpia_i,
  output logic [3:0] digito_o,
  output logic       acarreo_o
);

  bcd_t digito_q;
  bcd_t digito_d;

  always_comb begin
    digito_d = digito_q;
    if (limpia_i) begin
      digito_d = C_BCD_MIN;
    end else if (habilita_i) begin
      digito_d = bcd_paso(digito_q, sube_i);
    end
  end

  always_ff @(posedge reloj_i or posedge reset_i) begin
    if (reset_i) begin
      digito_q <= C_BCD_MIN;
    end else begin
      digito_q <= digito_d;
    end
  end

  assign acarreo_o = sube_i ? (digito_q >= C_BCD_MAX) : (digito_q == C_BCD_MIN);
  assign digito_o  = digito_q;

endmodule

// File: rtl/contador_bcd_4_digitos.sv
// Four-digit BCD up/down counter with prescaler and run/stop toggle.
// Holds the FSM, the prescaler, the digit chain and the wrap detection.
module contador_bcd_4_digitos
  import pkg_display::*;
#(
  parameter int P_DIVISOR = 100_000
) (
  input  logic       i_Reloj,
  input  logic       i_Reset,
  input  logic       i_Arranque,
  input  logic       i_Limpiar,
  input  logic       i_Direccion,
  output logic [3:0] o_Datos_0,
  output logic [3:0] o_Datos_1,
  output logic [3:0] o_Datos_2,
  output logic [3:0] o_Datos_3,
  output logic       o_Corriendo,
  output logic       o_Desborde
);

  localparam int C_ANCHO = (P_DIVISOR > 1) ? $clog2(P_DIVISOR) : 1;
  localparam logic [C_ANCHO-1:0] C_PRESC_MAX = C_ANCHO'(P_DIVISOR - 1);

  estado_t            estado_q;
  estado_t            estado_d;
  logic [C_ANCHO-1:0] presc_q;
  logic [C_ANCHO-1:0] presc_d;
  logic               desborde_q;
  logic               desborde_d;
  logic               tick;

  // habilita[i] = tick AND carries of all digits below i; habilita[4] marks a full wrap.
  logic               habilita [C_NUM_DIGITOS+1];
  logic               acarreo  [C_NUM_DIGITOS];
  logic [3:0]         digitos  [C_NUM_DIGITOS];

  always_comb begin
    estado_d = estado_q;
    if (i_Arranque) begin
      estado_d = (estado_q == DETENIDO) ? CORRIENDO : DETENIDO;
    end
  end

  assign tick = (estado_q == CORRIENDO) && (presc_q == C_PRESC_MAX);

  // Any path into or through DETENIDO parks the prescaler at 0 so a restart waits a full period.
  always_comb begin
    presc_d = presc_q + 1'b1;
    if (i_Limpiar || tick || (estado_q == DETENIDO) || (estado_d == DETENIDO)) begin
      presc_d = '0;
    end
  end

  assign habilita[0] = tick;

  generate
    for (genvar gi = 0; gi < C_NUM_DIGITOS; gi++) begin : g_digito
      digito_bcd u_digito (
        .reloj_i    (i_Reloj),
        .reset_i    (i_Reset),
        .habilita_i (habilita[gi]),
        .sube_i     (i_Direccion),
        .limpia_i   (i_Limpiar),
        .digito_o   (digitos[gi]),
        .acarreo_o  (acarreo[gi])
      );
      assign habilita[gi+1] = habilita[gi] & acarreo[gi];
    end
  endgenerate

  assign desborde_d = habilita[C_NUM_DIGITOS] & ~i_Limpiar;

  always_ff @(posedge i_Reloj or posedge i_Reset) begin
    if (i_Reset) begin
      estado_q   <= DETENIDO;
      presc_q    <= '0;
      desborde_q <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      presc_q    <= presc_d;
      desborde_q <= desborde_d;
    end
  end

  assign o_Datos_0   = digitos[0];
  assign o_Datos_1   = digitos[1];
  assign o_Datos_2   = digitos[2];
  assign o_Datos_3   = digitos[3];
  assign o_Corriendo = (estado_q == CORRIENDO);
  assign o_Desborde  = desborde_q;

endmodule

// File: tb/tb_contador_bcd_4_digitos.sv
// Directed bench for contador_bcd_4_digitos with P_DIVISOR=4.
// Inputs change and outputs are sampled on the falling edge.
module tb_contador_bcd_4_digitos;

  logic       i_Reloj = 1'b0;
  logic       i_Reset;
  logic       i_Arranque;
  logic       i_Limpiar;
  logic       i_Direccion;
  logic [3:0] o_Datos_0, o_Datos_1, o_Datos_2, o_Datos_3;
  logic       o_Corriendo;
  logic       o_Desborde;

  int checks = 0;
  int errors = 0;

  contador_bcd_4_digitos #(.P_DIVISOR(4)) dut (
    .i_Reloj     (i_Reloj),
    .i_Reset     (i_Reset),
    .i_Arranque  (i_Arranque),
    .i_Limpiar   (i_Limpiar),
    .i_Direccion (i_Direccion),
    .o_Datos_0   (o_Datos_0),
    .o_Datos_1   (o_Datos_1),
    .o_Datos_2   (o_Datos_2),
    .o_Datos_3   (o_Datos_3),
    .o_Corriendo (o_Corriendo),
    .o_Desborde  (o_Desborde)
  );

  always #5 i_Reloj = ~i_Reloj;

  function automatic logic [15:0] lectura();
    return {o_Datos_3, o_Datos_2, o_Datos_1, o_Datos_0};
  endfunction

  task automatic ciclos(input int n);
    repeat (n) @(negedge i_Reloj);
  endtask

  task automatic pulso_arranque();
    i_Arranque = 1'b1;
    @(negedge i_Reloj);
    i_Arranque = 1'b0;
  endtask

  task automatic pulso_limpiar();
    i_Limpiar = 1'b1;
    @(negedge i_Reloj);
    i_Limpiar = 1'b0;
  endtask

  task automatic test_reset();
    i_Reset = 1'b1; i_Arranque = 1'b0; i_Limpiar = 1'b0; i_Direccion = 1'b1;
    ciclos(2);
    checks++;
    if ({lectura(), o_Corriendo, o_Desborde} !== 18'h0) begin
      $display("FAIL reset_state got %h/%b/%b want 0000/0/0", lectura(), o_Corriendo, o_Desborde);
      errors++;
    end
    i_Reset = 1'b0;
    ciclos(1);
    $display("test_reset: power-on state checked");
  endtask

  task automatic test_count_up();
    i_Direccion = 1'b1;
    pulso_arranque();
    checks++;
    if (o_Corriendo !== 1'b1) begin
      $display("FAIL start_running got %b want 1", o_Corriendo); errors++;
    end
    ciclos(3);
    checks++;
    if (lectura() !== 16'h0000) begin
      $display("FAIL up_before_tick got %h want 0000", lectura()); errors++;
    end
    ciclos(1);
    checks++;
    if (lectura() !== 16'h0001) begin
      $display("FAIL up_first_tick got %h want 0001", lectura()); errors++;
    end
    ciclos(35);
    checks++;
    if (lectura() !== 16'h0009) begin
      $display("FAIL up_nine got %h want 0009", lectura()); errors++;
    end
    ciclos(1);
    checks++;
    if (lectura() !== 16'h0010 || o_Desborde !== 1'b0) begin
      $display("FAIL up_carry got %h/%b want 0010/0", lectura(), o_Desborde); errors++;
    end
    pulso_arranque();
    checks++;
    if (o_Corriendo !== 1'b0) begin
      $display("FAIL stop got %b want 0", o_Corriendo); errors++;
    end
    pulso_limpiar();
    checks++;
    if (lectura() !== 16'h0000 || o_Corriendo !== 1'b0) begin
      $display("FAIL clear_stopped got %h/%b want 0000/0", lectura(), o_Corriendo); errors++;
    end
    $display("test_count_up: first tick, carry, stop and clear checked");
  endtask

  task automatic test_reset_mid_run();
    i_Direccion = 1'b1;
    pulso_arranque();
    ciclos(123 * 4);
    checks++;
    if (lectura() !== 16'h0123) begin
      $display("FAIL reach_0123 got %h want 0123", lectura()); errors++;
    end
    #2 i_Reset = 1'b1;
    #1;
    checks++;
    if ({lectura(), o_Corriendo, o_Desborde} !== 18'h0) begin
      $display("FAIL async_reset got %h/%b/%b want 0000/0/0", lectura(), o_Corriendo, o_Desborde);
      errors++;
    end
    @(negedge i_Reloj);
    i_Reset = 1'b0;
    ciclos(1);
    $display("test_reset_mid_run: asynchronous reset from 0123 checked");
  endtask

  task automatic test_down_wrap();
    i_Direccion = 1'b0;
    pulso_arranque();
    ciclos(4);
    checks++;
    if (lectura() !== 16'h9999 || o_Desborde !== 1'b1) begin
      $display("FAIL down_wrap got %h/%b want 9999/1", lectura(), o_Desborde); errors++;
    end
    ciclos(1);
    checks++;
    if (lectura() !== 16'h9999 || o_Desborde !== 1'b0) begin
      $display("FAIL down_wrap_pulse got %h/%b want 9999/0", lectura(), o_Desborde); errors++;
    end
    ciclos(3);
    checks++;
    if (lectura() !== 16'h9998 || o_Desborde !== 1'b0) begin
      $display("FAIL down_9998 got %h/%b want 9998/0", lectura(), o_Desborde); errors++;
    end
    $display("test_down_wrap: 0000->9999->9998 checked");
  endtask

  task automatic test_up_wrap();
    i_Direccion = 1'b1;
    ciclos(4);
    checks++;
    if (lectura() !== 16'h9999 || o_Desborde !== 1'b0) begin
      $display("FAIL up_9999 got %h/%b want 9999/0", lectura(), o_Desborde); errors++;
    end
    ciclos(4);
    checks++;
    if (lectura() !== 16'h0000 || o_Desborde !== 1'b1) begin
      $display("FAIL up_wrap got %h/%b want 0000/1", lectura(), o_Desborde); errors++;
    end
    ciclos(1);
    checks++;
    if (o_Desborde !== 1'b0) begin
      $display("FAIL up_wrap_pulse got %b want 0", o_Desborde); errors++;
    end
    pulso_arranque();
    pulso_limpiar();
    $display("test_up_wrap: 9998->9999->0000 checked");
  endtask

  task automatic test_stop_restart();
    i_Direccion = 1'b1;
    pulso_arranque();
    ciclos(20);
    ciclos(2);
    pulso_arranque();
    checks++;
    if (lectura() !== 16'h0005 || o_Corriendo !== 1'b0) begin
      $display("FAIL stop_at_5 got %h/%b want 0005/0", lectura(), o_Corriendo); errors++;
    end
    ciclos(5);
    pulso_arranque();
    ciclos(3);
    checks++;
    if (lectura() !== 16'h0005) begin
      $display("FAIL restart_early got %h want 0005", lectura()); errors++;
    end
    ciclos(1);
    checks++;
    if (lectura() !== 16'h0006) begin
      $display("FAIL restart_full_period got %h want 0006", lectura()); errors++;
    end
    pulso_arranque();
    pulso_limpiar();
    $display("test_stop_restart: restart waits full period checked");
  endtask

  task automatic test_collision();
    i_Direccion = 1'b0;
    pulso_arranque();
    ciclos(4);
    i_Direccion = 1'b1;
    ciclos(3);
    pulso_limpiar();
    checks++;
    if (lectura() !== 16'h0000 || o_Desborde !== 1'b0 || o_Corriendo !== 1'b1) begin
      $display("FAIL clear_vs_tick got %h/%b/%b want 0000/0/1", lectura(), o_Desborde, o_Corriendo);
      errors++;
    end
    ciclos(3);
    checks++;
    if (lectura() !== 16'h0000) begin
      $display("FAIL clear_resets_presc got %h want 0000", lectura()); errors++;
    end
    ciclos(1);
    checks++;
    if (lectura() !== 16'h0001) begin
      $display("FAIL after_clear_tick got %h want 0001", lectura()); errors++;
    end
    i_Limpiar = 1'b1;
    pulso_arranque();
    i_Limpiar = 1'b0;
    checks++;
    if (lectura() !== 16'h0000 || o_Corriendo !== 1'b0) begin
      $display("FAIL clear_with_toggle got %h/%b want 0000/0", lectura(), o_Corriendo); errors++;
    end
    $display("test_collision: clear beats tick, clear with toggle checked");
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_reset_mid_run();
    test_down_wrap();
    test_up_wrap();
    test_stop_restart();
    test_collision();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
